// File: rtl/text_ram_ctrl_if.sv
// Host register bus and screen RAM write port of the text-mode controller.
// The host (or a bench) drives the strobe side through the master modport;
// the controller owns the RAM write port and cursor/status through slave.
interface text_ram_ctrl_if #(
  parameter int AW = 11
);
  logic          wr_stb;
  logic [3:0]    rs;
  logic [7:0]    data_in;
  logic [AW-1:0] ram_wraddr;
  logic [7:0]    ram_data;
  logic          ram_wren;
  logic [6:0]    cursor_x;
  logic [4:0]    cursor_y;
  logic          busy;
  logic [7:0]    status;

  modport master (
    output wr_stb, rs, data_in,
    input  ram_wraddr, ram_data, ram_wren, cursor_x, cursor_y, busy, status
  );

  modport slave (
    input  wr_stb, rs, data_in,
    output ram_wraddr, ram_data, ram_wren, cursor_x, cursor_y, busy, status
  );
endinterface

// File: rtl/text_ram_ctrl.sv
// Write-side controller for the text-mode screen RAM: decodes host register
// writes into character stores at an auto-advancing cursor and runs a
// clear-screen engine that sweeps every cell with the fill character.
// While the clear engine runs, ram_data holds the fill captured at the
// clear command, so later fill-register writes cannot disturb a sweep.
module text_ram_ctrl #(
  parameter int COLS = 80,
  parameter int ROWS = 25,
  parameter int AW   = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  text_ram_ctrl_if.slave  bus
);

  localparam logic [6:0]    LastX    = 7'(COLS - 1);
  localparam logic [4:0]    LastY    = 5'(ROWS - 1);
  localparam logic [AW-1:0] LastCell = AW'(COLS * ROWS - 1);

  typedef enum logic {
    StIdle,
    StClear
  } state_t;

  state_t        r_state, w_nextState;
  logic [AW-1:0] r_wraddr, w_nextAddr;
  logic [7:0]    r_data, w_nextData;
  logic          r_wren, w_nextWren;
  logic [6:0]    r_curX, w_nextX;
  logic [4:0]    r_curY, w_nextY;
  logic          r_drop, w_nextDrop;
  logic [7:0]    r_fill, w_nextFill;

  logic [AW-1:0] w_cellAddr;
  logic [4:0]    w_yInc;
  logic          w_busy;

  // Linear cell address of the cursor and the wrapping row increment.
  assign w_cellAddr = AW'(r_curY) * AW'(COLS) + AW'(r_curX);
  assign w_yInc     = (r_curY == LastY) ? 5'd0 : r_curY + 5'd1;
  assign w_busy     = (r_state == StClear);

  // State and output registers; every output is a flop or a flop decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_wraddr <= '0;
      r_data   <= 8'h00;
      r_wren   <= 1'b0;
      r_curX   <= 7'd0;
      r_curY   <= 5'd0;
      r_drop   <= 1'b0;
      r_fill   <= 8'h20;
    end else begin
      r_state  <= w_nextState;
      r_wraddr <= w_nextAddr;
      r_data   <= w_nextData;
      r_wren   <= w_nextWren;
      r_curX   <= w_nextX;
      r_curY   <= w_nextY;
      r_drop   <= w_nextDrop;
      r_fill   <= w_nextFill;
    end
  end

  // Register decode in IDLE, address sweep in CLEAR; strobes while busy only mark drop.
  always_comb begin
    w_nextState = r_state;
    w_nextAddr  = r_wraddr;
    w_nextData  = r_data;
    w_nextWren  = 1'b0;
    w_nextX     = r_curX;
    w_nextY     = r_curY;
    w_nextDrop  = r_drop;
    w_nextFill  = r_fill;
    case (r_state)
      StIdle: begin
        if (bus.wr_stb) begin
          case (bus.rs)
            4'd0: w_nextX = (bus.data_in > {1'b0, LastX}) ? LastX : bus.data_in[6:0];
            4'd1: w_nextY = (bus.data_in > {3'b000, LastY}) ? LastY : bus.data_in[4:0];
            4'd2: begin
              w_nextWren = 1'b1;
              w_nextAddr = w_cellAddr;
              w_nextData = bus.data_in;
              if (r_curX == LastX) begin
                w_nextX = 7'd0;
                w_nextY = w_yInc;
              end else begin
                w_nextX = r_curX + 7'd1;
              end
            end
            4'd3: begin
              if (bus.data_in[7]) w_nextDrop = 1'b0;
              if (bus.data_in[0]) begin
                w_nextState = StClear;
                w_nextWren  = 1'b1;
                w_nextAddr  = '0;
                w_nextData  = r_fill;
              end else if (bus.data_in[1]) begin
                w_nextX = 7'd0;
                w_nextY = w_yInc;
              end
            end
            4'd4: w_nextFill = bus.data_in;
            default: ;
          endcase
        end
      end
      StClear: begin
        if (bus.wr_stb) w_nextDrop = 1'b1;
        if (r_wraddr == LastCell) begin
          w_nextState = StIdle;
          w_nextX     = 7'd0;
          w_nextY     = 5'd0;
        end else begin
          w_nextWren = 1'b1;
          w_nextAddr = r_wraddr + 1'b1;
        end
      end
      default: w_nextState = StIdle;
    endcase
  end

  assign bus.ram_wraddr = r_wraddr;
  assign bus.ram_data   = r_data;
  assign bus.ram_wren   = r_wren;
  assign bus.cursor_x   = r_curX;
  assign bus.cursor_y   = r_curY;
  assign bus.busy       = w_busy;
  assign bus.status     = {6'b000000, r_drop, w_busy};

endmodule

// File: tb/tb_text_ram_ctrl.sv
// Bench for text_ram_ctrl: a table of single register writes with
// hand-computed results, then hand-written sequences for back-to-back
// stores, full clears, drops while busy and reset in the middle of a clear.
module tb_text_ram_ctrl;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  text_ram_ctrl_if #(.AW(11)) bus ();

  text_ram_ctrl #(.COLS(80), .ROWS(25), .AW(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [3:0]  rs;
    logic [7:0]  data;
    logic        expWren;
    logic [10:0] expAddr;
    logic [7:0]  expData;
    logic [6:0]  expX;
    logic [4:0]  expY;
    logic [7:0]  expStatus;
  } vec_t;

  vec_t vecs[$];

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs outside the bounded loops.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One-cycle strobe; returns at the negedge after the sampling edge.
  task automatic applyStimulus(input logic [3:0] rs, input logic [7:0] data);
    @(negedge clk);
    bus.wr_stb  = 1'b1;
    bus.rs      = rs;
    bus.data_in = data;
    @(negedge clk);
    bus.wr_stb  = 1'b0;
  endtask

  // Issues a clear command and follows the sweep cycle by cycle.
  task automatic runClear(input logic [7:0] cmd, input logic [7:0] expFill,
                          input logic [6:0] holdX, input logic [4:0] holdY,
                          input bit injectHost);
    int          wrenCycles = 0;
    int          busyCycles = 0;
    int          badStores  = 0;
    logic [10:0] expAddr    = 11'd0;
    bit          done       = 1'b0;
    @(negedge clk);
    bus.wr_stb  = 1'b1;
    bus.rs      = 4'd3;
    bus.data_in = cmd;
    for (int c = 0; c < 2100 && !done; c++) begin
      @(negedge clk);
      bus.wr_stb = 1'b0;
      if (c == 0) begin
        checkOutput("clr_busy_start", 32'(bus.busy), 32'd1);
        checkOutput("clr_hold_x", 32'(bus.cursor_x), 32'(holdX));
        checkOutput("clr_hold_y", 32'(bus.cursor_y), 32'(holdY));
      end
      if (bus.busy) busyCycles++;
      if (bus.ram_wren) begin
        if (bus.ram_wraddr !== expAddr || bus.ram_data !== expFill) badStores++;
        expAddr++;
        wrenCycles++;
      end
      if (injectHost) begin
        if (c == 10) begin
          bus.wr_stb  = 1'b1;
          bus.rs      = 4'd2;
          bus.data_in = 8'h99;
        end
        if (c == 12) checkOutput("status_busy_drop", 32'(bus.status), 32'h03);
        if (c == 20) begin
          bus.wr_stb  = 1'b1;
          bus.rs      = 4'd3;
          bus.data_in = 8'h80;
        end
      end
      if (!bus.busy) done = 1'b1;
    end
    checkOutput("clr_finished", 32'(done), 32'd1);
    checkOutput("clr_wren_cycles", 32'(wrenCycles), 32'd2000);
    checkOutput("clr_busy_cycles", 32'(busyCycles), 32'd2000);
    checkOutput("clr_bad_stores", 32'(badStores), 32'd0);
    checkOutput("clr_end_x", 32'(bus.cursor_x), 32'd0);
    checkOutput("clr_end_y", 32'(bus.cursor_y), 32'd0);
    checkOutput("clr_end_wren", 32'(bus.ram_wren), 32'd0);
    @(negedge clk);
    checkOutput("clr_no_extra_wren", 32'(bus.ram_wren), 32'd0);
  endtask

  initial begin
    int quietWren;
    compared    = 0;
    mismatched  = 0;
    rst_n       = 1'b0;
    bus.wr_stb  = 1'b0;
    bus.rs      = 4'd0;
    bus.data_in = 8'h00;

    vecs.push_back('{4'd2, 8'h41, 1'b1, 11'd0,    8'h41, 7'd1,  5'd0,  8'h00});
    vecs.push_back('{4'd0, 8'd79, 1'b0, 11'd0,    8'h00, 7'd79, 5'd0,  8'h00});
    vecs.push_back('{4'd1, 8'd24, 1'b0, 11'd0,    8'h00, 7'd79, 5'd24, 8'h00});
    vecs.push_back('{4'd2, 8'h42, 1'b1, 11'd1999, 8'h42, 7'd0,  5'd0,  8'h00});
    vecs.push_back('{4'd0, 8'd100, 1'b0, 11'd0,   8'h00, 7'd79, 5'd0,  8'h00});
    vecs.push_back('{4'd1, 8'd31, 1'b0, 11'd0,    8'h00, 7'd79, 5'd24, 8'h00});
    vecs.push_back('{4'd2, 8'h43, 1'b1, 11'd1999, 8'h43, 7'd0,  5'd0,  8'h00});
    vecs.push_back('{4'd0, 8'd5,  1'b0, 11'd0,    8'h00, 7'd5,  5'd0,  8'h00});
    vecs.push_back('{4'd1, 8'd3,  1'b0, 11'd0,    8'h00, 7'd5,  5'd3,  8'h00});
    vecs.push_back('{4'd2, 8'h44, 1'b1, 11'd245,  8'h44, 7'd6,  5'd3,  8'h00});
    vecs.push_back('{4'd3, 8'h02, 1'b0, 11'd0,    8'h00, 7'd0,  5'd4,  8'h00});
    vecs.push_back('{4'd1, 8'd24, 1'b0, 11'd0,    8'h00, 7'd0,  5'd24, 8'h00});
    vecs.push_back('{4'd0, 8'd10, 1'b0, 11'd0,    8'h00, 7'd10, 5'd24, 8'h00});
    vecs.push_back('{4'd3, 8'h02, 1'b0, 11'd0,    8'h00, 7'd0,  5'd0,  8'h00});
    vecs.push_back('{4'd0, 8'd78, 1'b0, 11'd0,    8'h00, 7'd78, 5'd0,  8'h00});
    vecs.push_back('{4'd1, 8'd2,  1'b0, 11'd0,    8'h00, 7'd78, 5'd2,  8'h00});
    vecs.push_back('{4'd2, 8'h45, 1'b1, 11'd238,  8'h45, 7'd79, 5'd2,  8'h00});
    vecs.push_back('{4'd2, 8'h46, 1'b1, 11'd239,  8'h46, 7'd0,  5'd3,  8'h00});
    vecs.push_back('{4'd9, 8'hFF, 1'b0, 11'd0,    8'h00, 7'd0,  5'd3,  8'h00});
    vecs.push_back('{4'd3, 8'h00, 1'b0, 11'd0,    8'h00, 7'd0,  5'd3,  8'h00});
    vecs.push_back('{4'd4, 8'h2E, 1'b0, 11'd0,    8'h00, 7'd0,  5'd3,  8'h00});

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_wren", 32'(bus.ram_wren), 32'd0);
    checkOutput("reset_addr", 32'(bus.ram_wraddr), 32'd0);
    checkOutput("reset_data", 32'(bus.ram_data), 32'd0);
    checkOutput("reset_x", 32'(bus.cursor_x), 32'd0);
    checkOutput("reset_y", 32'(bus.cursor_y), 32'd0);
    checkOutput("reset_status", 32'(bus.status), 32'h00);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rs, vecs[i].data);
      checkOutput($sformatf("vec%0d_wren", i), 32'(bus.ram_wren), 32'(vecs[i].expWren));
      if (vecs[i].expWren) begin
        checkOutput($sformatf("vec%0d_addr", i), 32'(bus.ram_wraddr), 32'(vecs[i].expAddr));
        checkOutput($sformatf("vec%0d_data", i), 32'(bus.ram_data), 32'(vecs[i].expData));
      end
      checkOutput($sformatf("vec%0d_x", i), 32'(bus.cursor_x), 32'(vecs[i].expX));
      checkOutput($sformatf("vec%0d_y", i), 32'(bus.cursor_y), 32'(vecs[i].expY));
      checkOutput($sformatf("vec%0d_status", i), 32'(bus.status), 32'(vecs[i].expStatus));
      if (vecs[i].expWren) begin
        @(negedge clk);
        checkOutput($sformatf("vec%0d_wren_low", i), 32'(bus.ram_wren), 32'd0);
      end
    end

    // Back-to-back character writes from cursor (0,3).
    @(negedge clk);
    bus.wr_stb  = 1'b1;
    bus.rs      = 4'd2;
    bus.data_in = 8'h50;
    @(negedge clk);
    bus.data_in = 8'h51;
    checkOutput("b2b_first_wren", 32'(bus.ram_wren), 32'd1);
    checkOutput("b2b_first_addr", 32'(bus.ram_wraddr), 32'd240);
    checkOutput("b2b_first_data", 32'(bus.ram_data), 32'h50);
    @(negedge clk);
    bus.wr_stb = 1'b0;
    checkOutput("b2b_second_wren", 32'(bus.ram_wren), 32'd1);
    checkOutput("b2b_second_addr", 32'(bus.ram_wraddr), 32'd241);
    checkOutput("b2b_second_data", 32'(bus.ram_data), 32'h51);
    checkOutput("b2b_x", 32'(bus.cursor_x), 32'd2);
    @(negedge clk);
    checkOutput("b2b_wren_low", 32'(bus.ram_wren), 32'd0);

    // Full clear with fill 0x2E, host writes injected while busy.
    runClear(8'h01, 8'h2E, 7'd2, 5'd3, 1'b1);
    checkOutput("status_after_drop", 32'(bus.status), 32'h02);
    applyStimulus(4'd3, 8'h80);
    checkOutput("status_drop_cleared", 32'(bus.status), 32'h00);

    // Clear and newline together: clear wins, cursor untouched until the end.
    applyStimulus(4'd0, 8'd10);
    applyStimulus(4'd1, 8'd5);
    runClear(8'h03, 8'h2E, 7'd10, 5'd5, 1'b0);
    checkOutput("clr_nl_status", 32'(bus.status), 32'h00);

    // Reset asserted in the middle of a clear.
    @(negedge clk);
    bus.wr_stb  = 1'b1;
    bus.rs      = 4'd3;
    bus.data_in = 8'h01;
    @(negedge clk);
    bus.wr_stb = 1'b0;
    repeat (500) @(negedge clk);
    checkOutput("rstclr_active_wren", 32'(bus.ram_wren), 32'd1);
    checkOutput("rstclr_active_addr", 32'(bus.ram_wraddr), 32'd500);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstclr_wren", 32'(bus.ram_wren), 32'd0);
    checkOutput("rstclr_busy", 32'(bus.busy), 32'd0);
    checkOutput("rstclr_addr", 32'(bus.ram_wraddr), 32'd0);
    checkOutput("rstclr_status", 32'(bus.status), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    quietWren = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.ram_wren) quietWren++;
    end
    checkOutput("rstclr_quiet", 32'(quietWren), 32'd0);
    applyStimulus(4'd2, 8'h61);
    checkOutput("rstclr_char_wren", 32'(bus.ram_wren), 32'd1);
    checkOutput("rstclr_char_addr", 32'(bus.ram_wraddr), 32'd0);
    checkOutput("rstclr_char_data", 32'(bus.ram_data), 32'h61);
    checkOutput("rstclr_char_x", 32'(bus.cursor_x), 32'd1);

    // Fill register back at its reset value after the reset.
    runClear(8'h01, 8'h20, 7'd1, 5'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
